// File: rtl/lfsr_addr_sequencer.sv
// Frame address sequencer: walks a 14-bit maximal-length LFSR, discards states above N_MAX,
// and offers each legal address once per frame over a valid/ready handshake.
module lfsr_addr_sequencer #(
  parameter logic [13:0] N_MAX = 14'd12282,
  parameter logic [13:0] SEED  = 14'h0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [13:0] addr_out,
  output logic        addr_valid,
  input  logic        addr_ready,
  output logic        busy,
  output logic        done,
  output logic [13:0] skip_cnt
);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e      state_q, state_d;
  logic [13:0] lfsr_q, lfsr_d;
  logic [13:0] accept_cnt_q, accept_cnt_d;
  logic [13:0] skip_cnt_q, skip_cnt_d;
  logic        done_q, done_d;
  logic [13:0] lfsr_next;
  logic        legal;

  assign lfsr_next = {lfsr_q[12:0], lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[11] ^ lfsr_q[1]};
  assign legal     = (lfsr_q <= N_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lfsr_q       <= SEED;
      accept_cnt_q <= '0;
      skip_cnt_q   <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      accept_cnt_q <= accept_cnt_d;
      skip_cnt_q   <= skip_cnt_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    accept_cnt_d = accept_cnt_q;
    skip_cnt_d   = skip_cnt_q;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          lfsr_d       = SEED;
          accept_cnt_d = '0;
          skip_cnt_d   = '0;
          state_d      = RUN;
        end
      end
      RUN: begin
        if (!legal) begin
          // Out-of-range states are dropped without involving the consumer.
          lfsr_d     = lfsr_next;
          skip_cnt_d = (skip_cnt_q == '1) ? skip_cnt_q : skip_cnt_q + 14'd1;
        end else if (addr_ready) begin
          lfsr_d       = lfsr_next;
          accept_cnt_d = accept_cnt_q + 14'd1;
          if (accept_cnt_q == N_MAX - 14'd1) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        // Abort overrides the frame but lets a coincident accept count.
        if (abort) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign addr_out   = lfsr_q;
  assign addr_valid = (state_q == RUN) && legal;
  assign busy       = (state_q == RUN);
  assign done       = done_q;
  assign skip_cnt   = skip_cnt_q;

endmodule

// File: tb/tb_lfsr_addr_sequencer.sv
// Self-checking bench for lfsr_addr_sequencer: directed frame scenarios with random backpressure,
// checked against a reference address list built from the LFSR recurrence.
module tb_lfsr_addr_sequencer;

  localparam int N = 12282;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0, abort = 1'b0, addr_ready = 1'b0;
  logic [13:0] addr_out, skip_cnt;
  logic        addr_valid, busy, done;

  logic        start_s = 1'b0, abort_s = 1'b0, ready_s = 1'b0;
  logic [13:0] a_addr, a_skip, b_addr, b_skip;
  logic        a_valid, a_busy, a_done, b_valid, b_busy, b_done;

  int n_assert = 0;
  int n_fail   = 0;
  int ref_q[$];
  int ref_skip;
  int acc_q[$];
  int run_cycles;
  int done_cnt;

  always #5 clk = ~clk;

  lfsr_addr_sequencer #(.N_MAX(14'd12282), .SEED(14'h0001)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .addr_out(addr_out),
    .addr_valid(addr_valid), .addr_ready(addr_ready), .busy(busy), .done(done), .skip_cnt(skip_cnt)
  );

  lfsr_addr_sequencer #(.N_MAX(14'd12282), .SEED(14'h2FFA)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_s), .abort(abort_s), .addr_out(a_addr),
    .addr_valid(a_valid), .addr_ready(ready_s), .busy(a_busy), .done(a_done), .skip_cnt(a_skip)
  );

  lfsr_addr_sequencer #(.N_MAX(14'd12282), .SEED(14'h2FFB)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_s), .abort(abort_s), .addr_out(b_addr),
    .addr_valid(b_valid), .addr_ready(ready_s), .busy(b_busy), .done(b_done), .skip_cnt(b_skip)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int step(input int x);
    return ((x << 1) & 16383) | ($countones(x & 'h3802) & 1);
  endfunction

  // Ordered list of legal addresses a frame must deliver, plus the illegal states met on the way.
  function automatic void build_ref(input int seed);
    int x;
    x = seed;
    ref_q.delete();
    ref_skip = 0;
    while (ref_q.size() < N) begin
      if (x <= N) ref_q.push_back(x);
      else ref_skip++;
      x = step(x);
    end
  endfunction

  task automatic run_frame(input int pct, input int abort_at, input string tag);
    bit          finished;
    bit          hold;
    logic [13:0] held;
    finished = 1'b0;
    hold     = 1'b0;
    held     = '0;
    acc_q.delete();
    run_cycles = 0;
    done_cnt   = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_after_start"}, int'(busy), 1);
    chk({tag, "_first_addr"}, int'(addr_out), 1);
    for (int cyc = 0; cyc < 40000 && !finished; cyc++) begin
      if (cyc > 0) @(negedge clk);
      abort = 1'b0;
      if (done) done_cnt++;
      if (!busy) begin
        finished = 1'b1;
        chk({tag, "_end_done"}, int'(done), 1);
        chk({tag, "_end_valid"}, int'(addr_valid), 0);
      end else begin
        run_cycles++;
        chk({tag, "_valid_rule"}, int'(addr_valid), int'(addr_out <= 14'(N)));
        chk({tag, "_nonzero"}, int'(addr_out != '0), 1);
        if (hold) chk({tag, "_hold"}, int'({addr_valid, addr_out}), int'({1'b1, held}));
        addr_ready = ($urandom_range(99) < pct);
        if (addr_valid && addr_ready) begin
          acc_q.push_back(int'(addr_out));
          if (acc_q.size() == abort_at) abort = 1'b1;
        end
        hold = addr_valid && !addr_ready;
        held = addr_out;
      end
    end
    chk({tag, "_timeout"}, int'(finished), 1);
    addr_ready = 1'b0;
    abort      = 1'b0;
    @(negedge clk);
    if (done) done_cnt++;
    chk({tag, "_done_once"}, done_cnt, 1);
  endtask

  task automatic check_seq(input string tag, input int exp_n);
    int first_bad;
    first_bad = -1;
    chk({tag, "_count"}, acc_q.size(), exp_n);
    for (int i = 0; i < acc_q.size(); i++) begin
      if (i >= ref_q.size() || acc_q[i] != ref_q[i]) begin
        first_bad = i;
        break;
      end
    end
    chk({tag, "_seq_first_bad_idx"}, first_bad, -1);
  endtask

  initial begin
    bit seen[16384];
    int bad;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_addr", int'(addr_out), 1);
    chk("rst_valid", int'(addr_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_skip", int'(skip_cnt), 0);
    chk("rst_seed_a", int'(a_addr), 'h2FFA);
    chk("rst_seed_b", int'(b_addr), 'h2FFB);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Seed at and just above the legal bound
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    chk("seed_a_valid", int'(a_valid), 1);
    chk("seed_a_busy", int'(a_busy), 1);
    chk("seed_b_valid", int'(b_valid), 0);
    chk("seed_b_busy", int'(b_busy), 1);
    chk("seed_b_skip0", int'(b_skip), 0);
    @(negedge clk);
    chk("seed_b_skip1", int'(b_skip), 1);
    chk("seed_a_held", int'(a_addr), 'h2FFA);
    chk("seed_a_held_valid", int'(a_valid), 1);
    chk("seed_a_skip", int'(a_skip), 0);
    abort_s = 1'b1;
    @(negedge clk);
    abort_s = 1'b0;
    chk("seed_a_abort_done", int'(a_done), 1);
    chk("seed_b_abort_done", int'(b_done), 1);
    chk("seed_a_abort_busy", int'(a_busy), 0);
    chk("seed_b_abort_busy", int'(b_busy), 0);
    @(negedge clk);
    chk("seed_a_done_pulse", int'(a_done), 0);
    chk("idle_abort_noeffect", int'(done), 0);

    build_ref(1);

    // Full frame, consumer always ready
    run_frame(100, 0, "full");
    check_seq("full", N);
    chk("full_first0", acc_q[0], 'h0001);
    chk("full_first1", acc_q[1], 'h0002);
    chk("full_first2", acc_q[2], 'h0005);
    chk("full_first3", acc_q[3], 'h000A);
    bad = 0;
    foreach (acc_q[i]) begin
      if (acc_q[i] < 1 || acc_q[i] > N || seen[acc_q[i]]) bad++;
      seen[acc_q[i]] = 1'b1;
    end
    chk("full_distinct_in_range", bad, 0);
    chk("full_skip_vs_cycles", int'(skip_cnt), run_cycles - N);
    chk("full_skip_vs_ref", int'(skip_cnt), ref_skip);

    // Abort coinciding with the 100th accept
    run_frame(100, 100, "abort");
    check_seq("abort", 100);

    // Restart after abort under 50% backpressure
    run_frame(50, 0, "bp");
    check_seq("bp", N);
    chk("bp_skip_vs_ref", int'(skip_cnt), ref_skip);

    // Reset mid-frame
    @(negedge clk);
    start      = 1'b1;
    addr_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_addr", int'(addr_out), 1);
    chk("midrst_valid", int'(addr_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_skip", int'(skip_cnt), 0);
    @(negedge clk);
    chk("midrst_no_done_a", int'(done), 0);
    rst_n      = 1'b1;
    addr_ready = 1'b0;
    @(negedge clk);
    chk("midrst_no_done_b", int'(done), 0);
    chk("midrst_idle", int'(busy), 0);
    run_frame(100, 4, "post_rst");
    check_seq("post_rst", 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
